// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host transmit path and its line filters:
// FSM state encoding, TX_ERR result codes, frame length and the
// microsecond-to-cycle conversion used to size the host timers.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } tx_state_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_NOACK   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // start + 8 data + parity + stop
    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);

    // Product first so clocks that are not whole MHz still convert exactly.
    function automatic int unsigned us_to_cyc(input int unsigned clk_hz,
                                              input int unsigned us);
        logic [63:0] prod;
        prod = 64'(clk_hz) * 64'(us);
        return 32'(prod / 64'd1_000_000);
    endfunction

    function automatic int unsigned max_u(input int unsigned a,
                                          input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
// Conditions one raw PS/2 line: a 2-FF synchroniser followed by a
// FILT_LEN-sample agreement filter. The output only moves once the
// synchronised level has differed from it for FILT_LEN consecutive samples,
// giving a raw-to-filtered latency of 2 + FILT_LEN cycles. Idle level is 1.
//
// Ports
//   clk   system clock
//   rst   synchronous active-high reset (output returns to 1)
//   raw   asynchronous line level
//   filt  filtered, clock-synchronous line level
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module ps2_line_filter #(
    parameter int unsigned FILT_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);

    localparam int unsigned       CNT_W    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILT_LEN - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            cnt   <= '0;
            filt  <= 1'b1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // cnt holds how many consecutive samples disagreed with filt
            if (sync2 == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                filt <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device transmitter. Accepts one command byte, inhibits the
// bus, issues the request-to-send, shifts the frame out on device-generated
// clock falls, checks the device ACK and reports a result code.
//
// Ports
//   CLK         system clock
//   RST         synchronous active-high reset
//   TX_DATA     command byte, taken when TX_VALID && TX_READY
//   TX_VALID    transfer request
//   TX_READY    high only while idle
//   TX_DONE     one-cycle pulse at end of transfer
//   TX_ERR      result code (ERR_OK / ERR_NOACK / ERR_TIMEOUT), held
//   BUSY        high while a transfer is in progress
//   PS2_CLK_IN  raw CLK line level (asynchronous)
//   PS2_DAT_IN  raw DAT line level (asynchronous)
//   PS2_CLK_OE  1 = pull CLK low
//   PS2_DAT_OE  1 = pull DAT low
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | lines released, waiting for TX_VALID
// INHIBIT   | CLK held low for INHIBIT_CYC cycles
// REQ       | CLK and DAT (start bit) low for SETUP_CYC cycles
// SEND      | CLK released, one frame bit presented per device fall
// ACK       | DAT released, sample device ACK on the next fall
// WAIT_IDLE | wait for both lines high, then report the result
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned INHIBIT_US = 100,
    parameter int unsigned SETUP_CYC  = 50,
    parameter int unsigned TIMEOUT_US = 15_000,
    parameter int unsigned FILT_LEN   = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic       TX_DONE,
    output logic [1:0] TX_ERR,
    output logic       BUSY,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DAT_IN,
    output logic       PS2_CLK_OE,
    output logic       PS2_DAT_OE
);

    localparam int unsigned INHIBIT_CYC = us_to_cyc(CLK_HZ, INHIBIT_US);
    localparam int unsigned TIMEOUT_CYC = us_to_cyc(CLK_HZ, TIMEOUT_US);
    localparam int unsigned TMR_MAX     = max_u(INHIBIT_CYC, SETUP_CYC);
    localparam int unsigned TMR_W       = $clog2(TMR_MAX + 1);
    localparam int unsigned WDOG_W      = $clog2(TIMEOUT_CYC + 1);

    localparam logic [TMR_W-1:0]  INH_LOAD   = TMR_W'(INHIBIT_CYC - 1);
    localparam logic [TMR_W-1:0]  SETUP_LOAD = TMR_W'(SETUP_CYC - 1);
    localparam logic [WDOG_W-1:0] WDOG_LOAD  = WDOG_W'(TIMEOUT_CYC - 1);
    localparam logic [BIT_W-1:0]  STOP_IDX   = BIT_W'(FRAME_BITS - 1);

    logic clk_f;
    logic dat_f;
    logic clk_f_prev;
    logic fall_q;

    tx_state_t               state_q,   state_d;
    logic [TMR_W-1:0]        tmr_q,     tmr_d;
    logic [WDOG_W-1:0]       wdog_q,    wdog_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]   frame_q,   frame_d;
    logic                    clk_oe_q,  clk_oe_d;
    logic                    dat_oe_q,  dat_oe_d;
    logic                    done_q,    done_d;
    logic [1:0]              err_q,     err_d;
    logic                    nack_q,    nack_d;
    logic [BIT_W-1:0]        next_idx;
    logic                    wdog_live;

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
        .clk  (CLK),
        .rst  (RST),
        .raw  (PS2_CLK_IN),
        .filt (clk_f)
    );

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (
        .clk  (CLK),
        .rst  (RST),
        .raw  (PS2_DAT_IN),
        .filt (dat_f)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            wdog_q     <= '0;
            bit_cnt_q  <= '0;
            frame_q    <= '0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= ERR_OK;
            nack_q     <= 1'b0;
            clk_f_prev <= 1'b1;
            fall_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            wdog_q     <= wdog_d;
            bit_cnt_q  <= bit_cnt_d;
            frame_q    <= frame_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            done_q     <= done_d;
            err_q      <= err_d;
            nack_q     <= nack_d;
            clk_f_prev <= clk_f;
            fall_q     <= clk_f_prev & ~clk_f;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        wdog_d    = wdog_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        clk_oe_d  = clk_oe_q;
        dat_oe_d  = dat_oe_q;
        done_d    = 1'b0;
        err_d     = err_q;
        nack_d    = nack_q;
        next_idx  = bit_cnt_q + BIT_W'(1);
        wdog_live = (state_q == SEND) || (state_q == ACK) || (state_q == WAIT_IDLE);

        // Watchdog runs while the device owns CLK; each fall reloads it.
        if (wdog_live) begin
            if (fall_q) begin
                wdog_d = WDOG_LOAD;
            end else if (wdog_q != '0) begin
                wdog_d = wdog_q - WDOG_W'(1);
            end
        end

        if (wdog_live && !fall_q && (wdog_q == '0)) begin
            state_d  = IDLE;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            done_d   = 1'b1;
            err_d    = ERR_TIMEOUT;
        end else begin
            case (state_q)
                IDLE: begin
                    if (TX_VALID) begin
                        // bit 0 is the start bit, driven during REQ
                        frame_d  = {1'b1, ~^TX_DATA, TX_DATA, 1'b0};
                        tmr_d    = INH_LOAD;
                        clk_oe_d = 1'b1;
                        state_d  = INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (tmr_q == '0) begin
                        tmr_d    = SETUP_LOAD;
                        dat_oe_d = ~frame_q[0];
                        state_d  = REQ;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                REQ: begin
                    if (tmr_q == '0) begin
                        clk_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        wdog_d    = WDOG_LOAD;
                        state_d   = SEND;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                SEND: begin
                    if (fall_q) begin
                        dat_oe_d  = ~frame_q[next_idx];
                        bit_cnt_d = next_idx;
                        if (next_idx == STOP_IDX) begin
                            state_d = ACK;
                        end
                    end
                end
                ACK: begin
                    if (fall_q) begin
                        nack_d  = dat_f;
                        state_d = WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_f && dat_f) begin
                        done_d  = 1'b1;
                        err_d   = nack_q ? ERR_NOACK : ERR_OK;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign TX_READY   = (state_q == IDLE);
    assign BUSY       = ~TX_READY;
    assign TX_DONE    = done_q;
    assign TX_ERR     = err_q;
    assign PS2_CLK_OE = clk_oe_q;
    assign PS2_DAT_OE = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Drives ps2_host_tx against a behavioural PS/2 device on open-drain lines.
// Timing constants are scaled down so the whole run stays short.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ps2_host_tx;

    localparam int CLK_HZ      = 4_000_000;
    localparam int INHIBIT_US  = 100;
    localparam int SETUP_CYC   = 20;
    localparam int TIMEOUT_US  = 500;
    localparam int FILT_LEN    = 8;
    localparam int INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
    localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_done;
    logic [1:0] tx_err;
    logic       busy;
    logic       clk_oe;
    logic       dat_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       clk_line;
    logic       dat_line;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int exp_err = 0;

    assign clk_line = ~(clk_oe | dev_clk_low);
    assign dat_line = ~(dat_oe | dev_dat_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .CLK_HZ     (CLK_HZ),
        .INHIBIT_US (INHIBIT_US),
        .SETUP_CYC  (SETUP_CYC),
        .TIMEOUT_US (TIMEOUT_US),
        .FILT_LEN   (FILT_LEN)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .TX_DATA    (tx_data),
        .TX_VALID   (tx_valid),
        .TX_READY   (tx_ready),
        .TX_DONE    (tx_done),
        .TX_ERR     (tx_err),
        .BUSY       (busy),
        .PS2_CLK_IN (clk_line),
        .PS2_DAT_IN (dat_line),
        .PS2_CLK_OE (clk_oe),
        .PS2_DAT_OE (dat_oe)
    );

    // counts pulses seen in the cycle before each rising edge
    always @(posedge clk) begin
        if (tx_done) done_cnt++;
    end

    initial begin
        #900_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Line level the device should see at the rise after fall k (1..10).
    function automatic logic exp_bit(input logic [7:0] d, input int k);
        if (k <= 8) return d[k-1];
        if (k == 9) return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        return 1'b1;
    endfunction

    // Request a transfer and time the inhibit and request phases; returns at
    // the first sample where the host has released CLK.
    task automatic start_tx(input logic [7:0] d, input string nm);
        int n;
        check($sformatf("%s ready_before", nm), tx_ready, 1);
        check($sformatf("%s err_held", nm), tx_err, exp_err);
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        check($sformatf("%s ready_drop", nm), tx_ready, 0);
        check($sformatf("%s busy", nm), busy, 1);
        n = 0;
        while (clk_oe && !dat_oe && n < INHIBIT_CYC + 10) begin
            n++;
            tick();
        end
        check($sformatf("%s inhibit_cycles", nm), n, INHIBIT_CYC);
        n = 0;
        while (clk_oe && dat_oe && n < SETUP_CYC + 10) begin
            n++;
            tick();
        end
        check($sformatf("%s setup_cycles", nm), n, SETUP_CYC);
        check($sformatf("%s clk_released", nm), clk_oe, 0);
        check($sformatf("%s start_bit", nm), dat_oe, 1);
    endtask

    // Device side: 11 clocks, sample bits on rises, optional ACK, optional
    // CLK glitch after clock 3 and stray TX_VALID after clock 5.
    task automatic dev_xfer(input logic [7:0] d, input bit ack, input int half,
                            input bit glitch, input bit stray, input string nm);
        int   base;
        int   n;
        logic oe_before;
        base = done_cnt;
        repeat (half) tick();
        for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            repeat (half) tick();
            dev_clk_low = 1'b0;
            if (k <= 10)
                check($sformatf("%s bit%0d", nm, k), dat_line, exp_bit(d, k));
            if (k == 11) dev_dat_low = 1'b0;
            if (k == 10) begin
                repeat (half / 2) tick();
                dev_dat_low = ack;
                repeat (half - half / 2) tick();
            end else if (k == 3 && glitch) begin
                oe_before = dat_oe;
                repeat (half / 2) tick();
                dev_clk_low = 1'b1;
                repeat (3) tick();
                dev_clk_low = 1'b0;
                repeat (half - half / 2 - 3) tick();
                check($sformatf("%s glitch_no_advance", nm), dat_oe, oe_before);
            end else if (k == 5 && stray) begin
                tx_data  = ~d;
                tx_valid = 1'b1;
                check($sformatf("%s ready_while_busy", nm), tx_ready, 0);
                tick();
                tx_valid = 1'b0;
                repeat (half - 1) tick();
            end else begin
                repeat (half) tick();
            end
        end
        n = 0;
        while (done_cnt == base && n < 200) begin
            n++;
            tick();
        end
        repeat (5) tick();
        check($sformatf("%s done_count", nm), done_cnt - base, 1);
        exp_err = ack ? 0 : 1;
        check($sformatf("%s err", nm), tx_err, exp_err);
        check($sformatf("%s clk_oe_idle", nm), clk_oe, 0);
        check($sformatf("%s dat_oe_idle", nm), dat_oe, 0);
        check($sformatf("%s ready_after", nm), tx_ready, 1);
        check($sformatf("%s busy_after", nm), busy, 0);
    endtask

    initial begin
        int n;
        int base;

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst ready", tx_ready, 1);
        check("rst busy", busy, 0);
        check("rst done", tx_done, 0);
        check("rst err", tx_err, 0);
        check("rst clk_oe", clk_oe, 0);
        check("rst dat_oe", dat_oe, 0);

        start_tx(8'hED, "ed");
        dev_xfer(8'hED, 1'b1, 40, 1'b0, 1'b0, "ed");

        start_tx(8'hFF, "ff");
        dev_xfer(8'hFF, 1'b1, 40, 1'b0, 1'b0, "ff");

        start_tx(8'hF4, "f4");
        dev_xfer(8'hF4, 1'b0, 40, 1'b0, 1'b0, "f4");

        // device never clocks
        start_tx(8'h12, "tmo");
        base = done_cnt;
        n = 0;
        while (!tx_done && n < TIMEOUT_CYC + 50) begin
            n++;
            tick();
        end
        check("tmo cycles", n, TIMEOUT_CYC);
        check("tmo err", tx_err, 2);
        check("tmo clk_oe", clk_oe, 0);
        check("tmo dat_oe", dat_oe, 0);
        exp_err = 2;
        repeat (3) tick();
        check("tmo done_count", done_cnt - base, 1);
        check("tmo ready", tx_ready, 1);

        // reset in the middle of a transfer
        start_tx(8'hAA, "rst");
        repeat (40) tick();
        for (int k = 1; k <= 4; k++) begin
            dev_clk_low = 1'b1;
            repeat (40) tick();
            dev_clk_low = 1'b0;
            check($sformatf("rst bit%0d", k), dat_line, exp_bit(8'hAA, k));
            repeat (40) tick();
        end
        dev_clk_low = 1'b1;
        repeat (20) tick();
        check("rst d4_presented", dat_oe, 1);
        base = done_cnt;
        rst = 1'b1;
        tick();
        check("rst mid clk_oe", clk_oe, 0);
        check("rst mid dat_oe", dat_oe, 0);
        check("rst mid ready", tx_ready, 1);
        check("rst mid busy", busy, 0);
        rst = 1'b0;
        dev_clk_low = 1'b0;
        exp_err = 0;
        repeat (60) tick();
        check("rst mid no_done", done_cnt - base, 0);
        start_tx(8'hAA, "aa2");
        dev_xfer(8'hAA, 1'b1, 40, 1'b0, 1'b0, "aa2");

        // CLK glitch and stray request while busy
        start_tx(8'h34, "glt");
        dev_xfer(8'h34, 1'b1, 40, 1'b1, 1'b1, "glt");

        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            bit         ack;
            int         half;
            string      nm;
            d    = 8'($urandom);
            ack  = ($urandom_range(0, 3) != 0);
            half = int'($urandom_range(30, 60));
            nm   = $sformatf("rnd%0d_%02h", i, d);
            start_tx(d, nm);
            dev_xfer(d, ack, half, 1'b0, 1'b0, nm);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
